// File: rtl/pipeline_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_scoreboard
// Purpose  : Load-use stall and operand forwarding control driven by a shift
//            register of in-flight destination records. Optional counters
//            enabled by defining SCOREBOARD_STATS_EN.
// Revision : 1.0
// ============================================================================
module pipeline_scoreboard #(
    parameter int STAGES   = 3,
    parameter int NSRC     = 2,
    parameter int REGADDR  = 5,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 31,
    localparam int SELW    = $clog2(STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic [REGADDR-1:0]        issue_rd,
    input  logic                      issue_regwrite,
    input  logic                      issue_memread,
    input  logic [NSRC*REGADDR-1:0]   src_addr,
    input  logic [NSRC-1:0]           src_used,
    input  logic [STAGES:0]           kill,
    output logic                      stall,
    output logic [NSRC*SELW-1:0]      fwd_sel,
`ifdef SCOREBOARD_STATS_EN
    output logic [31:0]               stall_count,
    output logic [31:0]               fwd_count,
`endif
    output logic [STAGES-1:0]         entry_valid
);

    localparam logic [REGADDR-1:0] c_zero_reg = REGADDR'(ZERO_REG);

    logic [STAGES-1:0]  r_valid;
    logic [STAGES-1:0]  r_regwrite;
    logic [STAGES-1:0]  r_memread;
    logic [REGADDR-1:0] r_rd [STAGES];

    logic                 w_stall;
    logic [NSRC*SELW-1:0] w_fwd_sel;
    logic [SELW-1:0]      w_hit_sel;
    logic                 w_hit_load;

    // The record leaving the last entry is dropped, so its kill bit has no effect.
    logic w_unused_kill;
    assign w_unused_kill = kill[STAGES];

    // Scanning from the oldest entry down lets the youngest producer win.
    always_comb begin
        w_stall    = 1'b0;
        w_fwd_sel  = '0;
        w_hit_sel  = '0;
        w_hit_load = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            w_hit_sel  = '0;
            w_hit_load = 1'b0;
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (r_valid[k] && r_regwrite[k] && src_used[i] &&
                    (r_rd[k] == src_addr[i*REGADDR +: REGADDR]) &&
                    (src_addr[i*REGADDR +: REGADDR] != c_zero_reg)) begin
                    w_hit_sel  = SELW'(k + 1);
                    w_hit_load = r_memread[k] && (k < LOAD_LAT);
                end
            end
            if (w_hit_load) begin
                w_stall = 1'b1;
            end else begin
                w_fwd_sel[i*SELW +: SELW] = w_hit_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_regwrite <= '0;
            r_memread  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            r_valid[0]    <= issue_valid & ~w_stall & ~kill[0];
            r_rd[0]       <= issue_rd;
            r_regwrite[0] <= issue_regwrite;
            r_memread[0]  <= issue_memread;
            // Downstream entries always drain, even while ID is stalled.
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k]    <= r_valid[k-1] & ~kill[k];
                r_rd[k]       <= r_rd[k-1];
                r_regwrite[k] <= r_regwrite[k-1];
                r_memread[k]  <= r_memread[k-1];
            end
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_fwd_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
            r_fwd_count   <= '0;
        end else begin
            if (w_stall && !kill[0] && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if ((|w_fwd_sel) && (r_fwd_count != 32'hFFFF_FFFF)) begin
                r_fwd_count <= r_fwd_count + 32'd1;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign fwd_count   = r_fwd_count;
`endif

    assign stall       = w_stall;
    assign fwd_sel     = w_fwd_sel;
    assign entry_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_scoreboard
// Purpose  : Scoreboard bench: driver predicts outputs from a queue-of-records
//            model, a negedge monitor pops and compares.
// Revision : 1.0
// ============================================================================
module tb_pipeline_scoreboard;

    localparam int STAGES   = 3;
    localparam int NSRC     = 2;
    localparam int REGADDR  = 5;
    localparam int LOAD_LAT = 1;
    localparam int ZERO_REG = 31;
    localparam int SELW     = $clog2(STAGES + 1);

    typedef struct {
        bit               v;
        bit [REGADDR-1:0] rd;
        bit               rw;
        bit               mr;
    } rec_t;

    typedef struct {
        bit                 stall;
        bit [NSRC*SELW-1:0] fwd;
        bit [STAGES-1:0]    ev;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    issue_valid;
    logic [REGADDR-1:0]      issue_rd;
    logic                    issue_regwrite;
    logic                    issue_memread;
    logic [NSRC*REGADDR-1:0] src_addr;
    logic [NSRC-1:0]         src_used;
    logic [STAGES:0]         kill;
    logic                    stall;
    logic [NSRC*SELW-1:0]    fwd_sel;
    logic [STAGES-1:0]       entry_valid;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0]             stall_count;
    logic [31:0]             fwd_count;
    logic [31:0]             m_stall_cnt = 0;
    logic [31:0]             m_fwd_cnt   = 0;
`endif

    rec_t mdl[STAGES];
    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipeline_scoreboard #(
        .STAGES(STAGES), .NSRC(NSRC), .REGADDR(REGADDR),
        .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_regwrite(issue_regwrite), .issue_memread(issue_memread),
        .src_addr(src_addr), .src_used(src_used), .kill(kill),
        .stall(stall), .fwd_sel(fwd_sel),
`ifdef SCOREBOARD_STATS_EN
        .stall_count(stall_count), .fwd_count(fwd_count),
`endif
        .entry_valid(entry_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest producer = lowest entry index holding a live writer of the source.
    function automatic exp_t predict(input logic [NSRC*REGADDR-1:0] sa, input logic [NSRC-1:0] su);
        exp_t e;
        e.stall = 0;
        e.fwd   = '0;
        for (int k = 0; k < STAGES; k++) e.ev[k] = mdl[k].v;
        for (int i = 0; i < NSRC; i++) begin
            int best = -1;
            bit [REGADDR-1:0] a = sa[i*REGADDR +: REGADDR];
            for (int k = 0; k < STAGES; k++)
                if (best < 0 && mdl[k].v && mdl[k].rw && mdl[k].rd == a && a != ZERO_REG && su[i])
                    best = k;
            if (best >= 0) begin
                if (mdl[best].mr && best < LOAD_LAT) e.stall = 1;
                else e.fwd[i*SELW +: SELW] = SELW'(best + 1);
            end
        end
        return e;
    endfunction

    task automatic cycle(input logic r, input logic iv, input logic [REGADDR-1:0] ird,
                         input logic irw, input logic imr, input logic [REGADDR-1:0] s0,
                         input logic [REGADDR-1:0] s1, input logic [1:0] su, input logic [3:0] kl);
        exp_t e;
        rec_t nx[STAGES];
        rst = r; issue_valid = iv; issue_rd = ird; issue_regwrite = irw;
        issue_memread = imr; src_addr = {s1, s0}; src_used = su; kill = kl;
        e = predict({s1, s0}, su);
        q.push_back(e);
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < STAGES; k++) nx[k] = '{v: 0, rd: 0, rw: 0, mr: 0};
        end else begin
            nx[0] = '{v: iv && !e.stall && !kl[0], rd: ird, rw: irw, mr: imr};
            for (int k = 1; k < STAGES; k++) begin
                nx[k] = mdl[k-1];
                if (kl[k]) nx[k].v = 0;
            end
        end
`ifdef SCOREBOARD_STATS_EN
        if (r) begin
            m_stall_cnt = 0; m_fwd_cnt = 0;
        end else begin
            if (e.stall && !kl[0]) m_stall_cnt++;
            if (e.fwd != 0) m_fwd_cnt++;
        end
`endif
        mdl = nx;
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("stall", 32'(stall), 32'(e.stall));
            check("fwd_sel", 32'(fwd_sel), 32'(e.fwd));
            check("entry_valid", 32'(entry_valid), 32'(e.ev));
        end
    end

    initial begin
        int guard;
        for (int k = 0; k < STAGES; k++) mdl[k] = '{v: 0, rd: 0, rw: 0, mr: 0};
        rst = 1; issue_valid = 0; issue_rd = 0; issue_regwrite = 0; issue_memread = 0;
        src_addr = 0; src_used = 0; kill = 0;
        @(posedge clk); #1;

        // ADD X3, then read X3 while it walks EX -> MEM -> WB -> gone
        cycle(0, 1, 3, 1, 0, 0, 0, 2'b00, 4'b0000);
        repeat (4) cycle(0, 0, 0, 0, 0, 3, 0, 2'b01, 4'b0000);
        // LDUR X5 then a dependent reader held across the stall
        cycle(0, 1, 5, 1, 1, 0, 0, 2'b00, 4'b0000);
        cycle(0, 1, 9, 1, 0, 0, 5, 2'b10, 4'b0000);
        cycle(0, 1, 9, 1, 0, 0, 5, 2'b10, 4'b0000);
        // X7 in entries 2 and 0; XZR writer never matches
        cycle(0, 1, 7, 1, 0, 0, 0, 2'b00, 4'b0000);
        cycle(0, 1, 31, 1, 0, 0, 0, 2'b00, 4'b0000);
        cycle(0, 1, 7, 1, 0, 0, 0, 2'b00, 4'b0000);
        cycle(0, 0, 0, 0, 0, 7, 31, 2'b11, 4'b0000);
        cycle(0, 0, 0, 0, 0, 31, 31, 2'b11, 4'b0000);
        // Branch squash with full entries
        cycle(0, 1, 1, 1, 0, 0, 0, 2'b00, 4'b0000);
        cycle(0, 1, 2, 1, 0, 0, 0, 2'b00, 4'b0000);
        cycle(0, 1, 4, 1, 0, 0, 0, 2'b00, 4'b0011);
        cycle(0, 0, 0, 0, 0, 1, 2, 2'b11, 4'b0000);
        // Stall and kill[0] in the same cycle
        cycle(0, 1, 6, 1, 1, 0, 0, 2'b00, 4'b0000);
        cycle(0, 1, 8, 1, 0, 6, 0, 2'b01, 4'b0001);
        cycle(0, 0, 0, 0, 0, 6, 8, 2'b11, 4'b0000);
        // Reset mid-run with entries full
        cycle(0, 1, 10, 1, 0, 0, 0, 2'b00, 4'b0000);
        cycle(0, 1, 11, 1, 0, 0, 0, 2'b00, 4'b0000);
        cycle(0, 1, 12, 1, 0, 0, 0, 2'b00, 4'b0000);
        cycle(1, 1, 13, 1, 0, 10, 11, 2'b11, 4'b0000);
        cycle(0, 0, 0, 0, 0, 11, 12, 2'b11, 4'b0000);

        for (int n = 0; n < 3000; n++) begin
            logic [REGADDR-1:0] r0, r1, rd;
            int x;
            x  = $urandom_range(0, 8); rd = (x == 8) ? 5'd31 : 5'(x);
            x  = $urandom_range(0, 8); r0 = (x == 8) ? 5'd31 : 5'(x);
            x  = $urandom_range(0, 8); r1 = (x == 8) ? 5'd31 : 5'(x);
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), rd,
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0), r0, r1,
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
        end

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #1;
        total++;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
`ifdef SCOREBOARD_STATS_EN
        check("stall_count", stall_count, m_stall_cnt);
        check("fwd_count", fwd_count, m_fwd_cnt);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
